// File: rtl/packet_buffer_ingress_arbiter_if.sv
// Ingress/egress stream bundle for packet_buffer_ingress_arbiter.
// Handshake: a beat moves on a cycle where valid and ready are both high.
// Valid never waits on ready. The arbiter forwards the granted source's
// valid and gives that source the buffer's ready.
// 'master' is the arbiter's view because it drives the buffer write port.
// 'slave' is the environment's view: it drives the sources and the buffer ready.
interface packet_buffer_ingress_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS*32-1:0] s_tdata;
    logic [NUM_PORTS-1:0]    s_tvalid;
    logic [NUM_PORTS-1:0]    s_tready;
    logic [31:0]             m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic                    m_tlast;
    logic [3:0]              m_tkeep;

    modport master (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tkeep
    );

    modport slave (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tkeep
    );
endinterface

// File: rtl/packet_buffer_ingress_arbiter.sv
// packet_buffer_ingress_arbiter: packet-granular round-robin sharing of one
// packet-buffer write port between NUM_PORTS framed ingress streams.
// Each frame is a header {len[31:16], id[15:0]} followed by ceil(len/4) words.
// The datapath is zero-latency muxing of the granted source. Only the grant,
// the beat counter and the packet FSM are registered.
// Optional feature: define PKT_ARB_LEN_CHECK_EN to enable the length check.
// A frame is then legal only when 64 <= len <= 1500. Illegal frames are
// drained without being forwarded and are counted in drop_count.
// Without the macro every frame is forwarded and drop_count stays 0.
module packet_buffer_ingress_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    packet_buffer_ingress_arbiter_if.master bus,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
    output logic                          busy,
    output logic [DROP_CNT_WIDTH-1:0]     drop_count,
    output logic [1:0]                    state_o
);
    localparam int GW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [GW-1:0]             last_grant_q, last_grant_d;
    logic [14:0]               remaining_q, remaining_d;
    logic [1:0]                len_lo_q, len_lo_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    logic [31:0]          port_data [NUM_PORTS];
    logic [31:0]          g_data;
    logic                 g_valid;
    logic [15:0]          len;
    logic [16:0]          len_p3;
    logic [14:0]          words;
    logic                 frame_ok;
    logic                 hit;
    logic [GW-1:0]        hit_idx;
    logic [GW-1:0]        cand;
    logic [NUM_PORTS-1:0] s_tready_c;
    logic [31:0]          m_tdata_c;
    logic                 m_tvalid_c;
    logic                 m_tlast_c;
    logic [3:0]           m_tkeep_c;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign port_data[gi] = bus.s_tdata[32*gi +: 32];
    end

    assign g_data  = port_data[grant_q];
    assign g_valid = bus.s_tvalid[grant_q];
    assign len     = g_data[31:16];
    assign len_p3  = {1'b0, len} + 17'd3;
    assign words   = len_p3[16:2];

`ifdef PKT_ARB_LEN_CHECK_EN
    assign frame_ok = (len >= 16'd64) && (len <= 16'd1500);
`else
    assign frame_ok = 1'b1;
`endif

    // Round-robin search starting one past the port that finished last.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NUM_PORTS);
            if (!hit && bus.s_tvalid[cand]) begin
                hit     = 1'b1;
                hit_idx = cand;
            end
        end
    end

    // Packet FSM next state and the combinational stream mux.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        remaining_d  = remaining_q;
        len_lo_d     = len_lo_q;
        drop_d       = drop_q;
        s_tready_c   = '0;
        m_tdata_c    = '0;
        m_tvalid_c   = 1'b0;
        m_tlast_c    = 1'b0;
        m_tkeep_c    = 4'h0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    grant_d = hit_idx;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (frame_ok) begin
                    m_tdata_c           = g_data;
                    m_tvalid_c          = g_valid;
                    s_tready_c[grant_q] = bus.m_tready;
                    m_tkeep_c           = 4'hF;
                    m_tlast_c           = (words == '0);
                    if (g_valid && bus.m_tready) begin
                        if (words == '0) begin
                            last_grant_d = grant_q;
                            state_d      = ST_IDLE;
                        end else begin
                            remaining_d = words;
                            len_lo_d    = len[1:0];
                            state_d     = ST_PAYLOAD;
                        end
                    end
                end else begin
                    // Illegal header: swallow it regardless of the buffer.
                    s_tready_c[grant_q] = 1'b1;
                    if (g_valid) begin
                        if (drop_q != '1) begin
                            drop_d = drop_q + 1'b1;
                        end
                        if (words == '0) begin
                            last_grant_d = grant_q;
                            state_d      = ST_IDLE;
                        end else begin
                            remaining_d = words;
                            state_d     = ST_DROP;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                m_tdata_c           = g_data;
                m_tvalid_c          = g_valid;
                s_tready_c[grant_q] = bus.m_tready;
                m_tlast_c           = (remaining_q == 15'd1);
                m_tkeep_c           = 4'hF;
                if (remaining_q == 15'd1) begin
                    case (len_lo_q)
                        2'd1:    m_tkeep_c = 4'h8;
                        2'd2:    m_tkeep_c = 4'hC;
                        2'd3:    m_tkeep_c = 4'hE;
                        default: m_tkeep_c = 4'hF;
                    endcase
                end
                if (g_valid && bus.m_tready) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 15'd1) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                s_tready_c[grant_q] = 1'b1;
                if (g_valid) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 15'd1) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_PORTS - 1);
            remaining_q  <= '0;
            len_lo_q     <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            remaining_q  <= remaining_d;
            len_lo_q     <= len_lo_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.s_tready = s_tready_c;
    assign bus.m_tdata  = m_tdata_c;
    assign bus.m_tvalid = m_tvalid_c;
    assign bus.m_tlast  = m_tlast_c;
    assign bus.m_tkeep  = m_tkeep_c;
    assign grant_id     = grant_q;
    assign busy         = (state_q != ST_IDLE);
    assign drop_count   = drop_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_packet_buffer_ingress_arbiter.sv
// Bench for packet_buffer_ingress_arbiter: randomized framed sources, a
// frame-level reference model compared every cycle, and literal pins for
// the headline scenarios.
module tb_packet_buffer_ingress_arbiter;
    localparam int NP = 4;
    localparam int GW = $clog2(NP);
    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_buffer_ingress_arbiter_if #(.NUM_PORTS(NP)) bus ();
    logic [GW-1:0] grant_id;
    logic          busy;
    logic [DW-1:0] drop_count;
    logic [1:0]    state_dbg;

    packet_buffer_ingress_arbiter #(.NUM_PORTS(NP), .DROP_CNT_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id),
        .busy(busy), .drop_count(drop_count), .state_o(state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit run_en   = 1'b0;

    // Per-port frame store: flat word stream plus the length of each frame.
    logic [31:0] src_words [NP][$];
    int          flen      [NP][$];
    int          vprob [NP];
    int          rprob;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] keep_for(input int len);
        case (len % 4)
            0:       return 4'hF;
            1:       return 4'h8;
            2:       return 4'hC;
            default: return 4'hE;
        endcase
    endfunction

    function automatic bit frame_valid(input int len);
`ifdef PKT_ARB_LEN_CHECK_EN
        return (len >= 64) && (len <= 1500);
`else
        return (len >= 0);
`endif
    endfunction

    // ---------------- source / sink driver ----------------
    int ptr [NP];
    bit src_hs [NP];

    always @(posedge clk) begin
        #1;
        if (!run_en) begin
            bus.s_tvalid = '0;
            bus.s_tdata  = '0;
            bus.m_tready = 1'b0;
            for (int p = 0; p < NP; p++) ptr[p] = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (src_hs[p]) begin
                    ptr[p]++;
                    bus.s_tvalid[p] = 1'b0;
                end
                if (!bus.s_tvalid[p]) begin
                    if (ptr[p] < src_words[p].size() && int'($urandom_range(0, 99)) < vprob[p]) begin
                        bus.s_tvalid[p] = 1'b1;
                        bus.s_tdata[32*p +: 32] = src_words[p][ptr[p]];
                    end else begin
                        bus.s_tdata[32*p +: 32] = $urandom();
                    end
                end
            end
            bus.m_tready = (int'($urandom_range(0, 99)) < rprob);
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit          m_active;
    bit          m_fwd;
    int          m_port, m_idx, m_len, m_nw, m_base;
    int          last_g, m_gid, exp_drop;
    int          fidx  [NP];
    int          mcons [NP];
    logic [NP-1:0] mdl_rdy;
    bit          mdl_vin;
    bit          found;
    int          q;

    always @(negedge clk) begin
        if (!run_en) begin
            m_active = 1'b0;
            last_g   = NP - 1;
            m_gid    = 0;
            exp_drop = 0;
            for (int p = 0; p < NP; p++) begin
                fidx[p]   = 0;
                mcons[p]  = 0;
                src_hs[p] = 1'b0;
            end
        end else begin
            chk("drop_count", drop_count, exp_drop);
            if (!m_active) begin
                chk("idle_busy", busy, 0);
                chk("idle_m_tvalid", bus.m_tvalid, 0);
                chk("idle_s_tready", bus.s_tready, 0);
                chk("idle_grant_id", grant_id, m_gid);
                found = 1'b0;
                for (int k = 1; k <= NP; k++) begin
                    q = (last_g + k) % NP;
                    if (!found && bus.s_tvalid[q] && fidx[q] < flen[q].size()) begin
                        found    = 1'b1;
                        m_active = 1'b1;
                        m_port   = q;
                        m_gid    = q;
                        m_idx    = 0;
                        m_len    = flen[q][fidx[q]];
                        m_nw     = (m_len + 3) / 4;
                        m_fwd    = frame_valid(m_len);
                        m_base   = mcons[q];
                    end
                end
            end else begin
                mdl_vin = bus.s_tvalid[m_port];
                mdl_rdy = '0;
                mdl_rdy[m_port] = m_fwd ? bus.m_tready : 1'b1;
                chk("busy", busy, 1);
                chk("grant_id", grant_id, m_port);
                chk("s_tready", bus.s_tready, mdl_rdy);
                chk("m_tvalid", bus.m_tvalid, m_fwd && mdl_vin);
                if (m_fwd && mdl_vin) begin
                    chk("m_tdata", bus.m_tdata, src_words[m_port][m_base + m_idx]);
                    chk("m_tlast", bus.m_tlast, m_idx == m_nw);
                    chk("m_tkeep", bus.m_tkeep,
                        (m_idx == m_nw && m_idx > 0) ? keep_for(m_len) : 4'hF);
                end
                if (mdl_vin && mdl_rdy[m_port]) begin
                    if (m_idx == 0 && !m_fwd && exp_drop < (1 << DW) - 1) exp_drop++;
                    m_idx++;
                    if (m_idx > m_nw) begin
                        m_active = 1'b0;
                        last_g   = m_port;
                        mcons[m_port] += m_nw + 1;
                        fidx[m_port]++;
                    end
                end
            end
            for (int p = 0; p < NP; p++) src_hs[p] = bus.s_tvalid[p] && bus.s_tready[p];
        end
    end

    // ---------------- observation counters for literal pins ----------------
    int         obs_beats = 0;
    int         obs_tlast = 0;
    logic [3:0] obs_last_keep = 4'h0;
    int         obs_src [NP] = '{default: 0};
    int         obs_grants [$];
    bit         busy_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
            obs_beats++;
            if (bus.m_tlast === 1'b1) begin
                obs_tlast++;
                obs_last_keep = bus.m_tkeep;
            end
        end
        for (int p = 0; p < NP; p++)
            if (bus.s_tvalid[p] === 1'b1 && bus.s_tready[p] === 1'b1) obs_src[p]++;
        if (busy === 1'b1 && !busy_prev) obs_grants.push_back(int'(grant_id));
        busy_prev = (busy === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame(input int p, input int len);
        int          nw;
        logic [31:0] lv;
        nw = (len + 3) / 4;
        lv = len;
        flen[p].push_back(len);
        src_words[p].push_back({lv[15:0], 16'h0A00 | 16'(p)});
        for (int k = 0; k < nw; k++) src_words[p].push_back($urandom());
    endtask

    task automatic set_rates(input int vp, input int rp);
        for (int p = 0; p < NP; p++) vprob[p] = vp;
        rprob = rp;
    endtask

    task automatic run_until_done(input int limit);
        int cyc;
        bit done;
        cyc = 0;
        do begin
            @(negedge clk);
            #2;
            done = !m_active;
            for (int p = 0; p < NP; p++) if (fidx[p] != flen[p].size()) done = 1'b0;
            cyc++;
        end while (!done && cyc < limit);
        chk("drain_timeout", done, 1);
    endtask

    // Called a little after a falling edge; asserts reset and checks outputs.
    task automatic apply_reset();
        #1;
        run_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rst_s_tready", bus.s_tready, 0);
        chk("rst_m_tvalid", bus.m_tvalid, 0);
        chk("rst_m_tlast", bus.m_tlast, 0);
        chk("rst_m_tkeep", bus.m_tkeep, 0);
        chk("rst_m_tdata", bus.m_tdata, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_state", state_dbg, 0);
        for (int p = 0; p < NP; p++) begin
            flen[p].delete();
            src_words[p].delete();
        end
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int b0, t0, g0, s0;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        set_rates(100, 100);
        repeat (3) @(negedge clk);
        apply_reset();
        run_en = 1'b1;

        // Single len-64 packet on port 0.
        b0 = obs_beats;
        push_frame(0, 64);
        run_until_done(500);
        chk("len64_beats", obs_beats - b0, 17);
        chk("len64_keep", obs_last_keep, 4'hF);
        chk("len64_drop", drop_count, 0);

        // Tail byte enables for len 65/66/67 on port 1.
        b0 = obs_beats; push_frame(1, 65); run_until_done(500);
        chk("len65_beats", obs_beats - b0, 18);
        chk("len65_keep", obs_last_keep, 4'h8);
        push_frame(1, 66); run_until_done(500);
        chk("len66_keep", obs_last_keep, 4'hC);
        push_frame(1, 67); run_until_done(500);
        chk("len67_keep", obs_last_keep, 4'hE);

`ifdef PKT_ARB_LEN_CHECK_EN
        // Short frame drained and counted, then a max-size frame forwarded.
        b0 = obs_beats; s0 = obs_src[2];
        push_frame(2, 10); run_until_done(500);
        chk("drop_beats", obs_beats - b0, 0);
        chk("drop_src_beats", obs_src[2] - s0, 4);
        chk("drop_count_1", drop_count, 1);
        b0 = obs_beats;
        push_frame(3, 1500); run_until_done(2000);
        chk("len1500_beats", obs_beats - b0, 376);
`else
        // Zero-length frame is a lone header carrying tlast.
        b0 = obs_beats; t0 = obs_tlast;
        push_frame(0, 0); run_until_done(500);
        chk("len0_beats", obs_beats - b0, 1);
        chk("len0_tlast", obs_tlast - t0, 1);
        chk("len0_keep", obs_last_keep, 4'hF);
`endif

        // Random buffer back-pressure during a len-100 packet.
        set_rates(100, 50);
        b0 = obs_beats;
        push_frame(1, 100); run_until_done(2000);
        chk("len100_beats", obs_beats - b0, 26);
        chk("len100_keep", obs_last_keep, 4'hF);

        // Reset in the middle of a payload.
        set_rates(100, 100);
        b0 = obs_beats;
        push_frame(0, 64);
        t0 = 0;
        while (obs_beats - b0 < 5 && t0 < 200) begin
            @(negedge clk);
            #1;
            t0++;
        end
        chk("reach_payload", obs_beats - b0, 5);
        apply_reset();

        // All ports continuously valid: fair packet order from port 0.
        push_frame(0, 64); push_frame(0, 64);
        push_frame(1, 64); push_frame(2, 64); push_frame(3, 64);
        g0 = obs_grants.size();
        run_en = 1'b1;
        run_until_done(1000);
        chk("order_count", obs_grants.size() - g0, 5);
        for (int i = 0; i < 5; i++)
            if (g0 + i < obs_grants.size()) chk("order_grant", obs_grants[g0 + i], exp_order[i]);

        // Randomized traffic rounds.
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NP; p++) vprob[p] = $urandom_range(30, 100);
            rprob = $urandom_range(50, 95);
            for (int f = 0; f < 25; f++) begin
                int p, sel, len;
                p   = $urandom_range(0, NP - 1);
                sel = $urandom_range(0, 7);
                case (sel)
                    0:       len = $urandom_range(0, 63);
                    1:       len = ($urandom_range(0, 1) != 0) ? 1500 : 1501;
                    2:       len = 63 + $urandom_range(0, 2);
                    default: len = $urandom_range(64, 200);
                endcase
                push_frame(p, len);
            end
            run_until_done(30000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/packet_buffer_ingress_arbiter.md
Name: packet_buffer_ingress_arbiter

Overview:
- Shares the single packet-buffer write port between NUM_PORTS ingress interfaces.
- Each source presents a framed stream: one 32-bit packet_header_t word {packet_length[31:16], interface_id[15:0]}, then ceil(packet_length/4) payload words.
- Arbitration is round-robin at packet granularity. The header is parsed to sequence the payload and generate tlast/tkeep.
- Out-of-range frames are drained and counted, never forwarded.

Parameters:
- NUM_PORTS, 4, number of ingress sources (>=2).
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- s_tdata  input  NUM_PORTS*32  source data; port i occupies bits [32*i+31:32*i].
- s_tvalid  input  NUM_PORTS  per-source valid.
- s_tready  output  NUM_PORTS  per-source ready.
- m_tdata  output  32  buffer write data.
- m_tvalid  output  1  buffer write valid.
- m_tready  input  1  buffer accepts the beat.
- m_tlast  output  1  last beat of the packet.
- m_tkeep  output  4  byte enables; bit 3 = byte in [31:24].
- grant_id  output  $clog2(NUM_PORTS)  currently granted port.
- busy  output  1  a packet is in progress (state != IDLE).
- drop_count  output  DROP_CNT_WIDTH  count of dropped frames, saturating.

Behaviour:
- Reset values: s_tready=0, m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, grant_id=0, busy=0, drop_count=0, last_grant=NUM_PORTS-1, state=IDLE.
- Handshake: a beat transfers when valid&ready are both high. Only the granted port may see s_tready=1.
- Forwarding datapath:
  - m_tdata = s_tdata[grant], with zero latency.
  - m_tvalid = s_tvalid[grant], s_tready[grant] = m_tready.
  - m_tvalid never depends on m_tready.
- FSM states: IDLE, HEADER, PAYLOAD, DROP.
- IDLE:
  - Search ports last_grant+1 .. last_grant+NUM_PORTS (mod NUM_PORTS) for the first with s_tvalid=1.
  - On a hit: register grant_id and go to HEADER next cycle. This is a 1-cycle arbitration bubble per packet.
  - No outputs are asserted in IDLE.
- HEADER:
  - len = s_tdata[grant][31:16].
  - words = (len+3)>>2, computed in 15 bits.
  - Valid frame, with len=0 (only when the length check is compiled out): forward the header with m_tlast=1 and m_tkeep=4'hF. On handshake go to IDLE.
  - Valid frame, with len>0: forward the header with m_tlast=0 and m_tkeep=4'hF. On handshake load remaining=words, latch len[1:0], and go to PAYLOAD.
  - Invalid frame: m_tvalid=0 and s_tready[grant]=1. On acceptance increment drop_count, saturating at all-ones. Load remaining=words and go to DROP, or go to IDLE if words==0.
- PAYLOAD:
  - Forward beats. Each handshake decrements remaining.
  - m_tlast=1 when remaining==1.
  - Last-beat m_tkeep from len[1:0]: 0 gives F, 1 gives 8, 2 gives C, 3 gives E. Non-last beats use F.
  - On the last handshake: last_grant=grant and go to IDLE.
- DROP:
  - s_tready[grant]=1 and m_tvalid=0. Each accepted beat decrements remaining.
  - At the final beat: last_grant=grant and go to IDLE.
- Stalls:
  - m_tready low holds state and counters.
  - s_tvalid low mid-packet inserts bubbles; the grant is never released mid-packet.
- Other sources' valid changes mid-packet have no effect.
- Reset mid-packet: immediate return to reset values. The partial packet is abandoned and the source is responsible for resync.
- busy=1 in HEADER, PAYLOAD and DROP.

Optional Feature:
- Macro: PKT_ARB_LEN_CHECK_EN.
- Defined: a frame is valid only if 64 <= len <= 1500 (MIN_ETH_FRAME_LENGTH / MAX_ETH_FRAME_LENGTH); otherwise it takes the drop path.
- Undefined:
  - Every frame is valid and the DROP state is unreachable.
  - drop_count is tied to 0.
  - len=0 gives a single-beat packet: header with tlast.

Test Plan:
- Single packet on port 0, header 0x0040_0000 (len 64) -> 17 m_tvalid beats; beat 17 has tlast=1, tkeep=F; drop_count=0.
- len 65 on port 1 -> 18 beats; last beat tkeep=8; len 66 gives C, len 67 gives E.
- Ports 0,1,2,3 all valid continuously, each sending len 64 -> grant order 0,1,2,3,0; one idle cycle between packets; no interleaving.
- With PKT_ARB_LEN_CHECK_EN: port 2 sends len 10 (3 payload words) -> no m_tvalid; 4 source beats consumed; drop_count=1. Then port 3 with len 1500 is forwarded as 376 beats.
- Toggle m_tready randomly at 50% during a len 100 packet -> m_tdata stable while stalled; exactly 26 beats transfer; tkeep=F on last.
- Assert rst during PAYLOAD beat 5 -> next cycle all outputs at reset values. After release, port 0 wins first when all ports are valid.
